goldschmidt_ctrl: RTL and testbench

Sequencing controller for the Goldschmidt divider datapath. Accepts one divide request (dividend, divisor, initial reciprocal approximation) through a start/busy/done handshake and holds the operands stable on the datapath inputs. Steps the datapath's shared multiplier through the load, refine and final phases by driving its K-select, N/D operand-select and register-enable controls. Captures the rounded 16-bit quotient when the sequence completes.

---
 rtl/goldschmidt_ctrl.sv | 168 ++++++++++++++++
 tb/tb_goldschmidt_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/goldschmidt_ctrl.sv
// goldschmidt_ctrl: sequencing controller for a Goldschmidt divider datapath.
// Accepts one divide request via start/busy/done, holds the operands on the
// datapath inputs and walks the shared multiplier through load, ITERS
// refinement pairs and a final product, then captures the rounded quotient.
// Optional feature macro: GS_DIVZERO_EN (zero divisor short-circuits to a
// saturated quotient with the dz flag set).
module goldschmidt_ctrl #(
  parameter int ITERS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] N_in,
  input  logic [15:0] D_in,
  input  logic [15:0] IA_in,
  input  logic [15:0] result,
  output logic [15:0] N,
  output logic [15:0] D,
  output logic [15:0] IA,
  output logic        kSelect,
  output logic [1:0]  ndSelect,
  output logic        nEnable,
  output logic        dEnable,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic        dz
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_D = 3'd1,
    LOAD_N = 3'd2,
    IT_N   = 3'd3,
    IT_D   = 3'd4,
    FINAL  = 3'd5,
    CAPT   = 3'd6
  } state_t;

  // Counter value seen in the last IT_D step (counter counts completed pairs).
  localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

  state_t      state;
  state_t      next_state;
  logic [2:0]  iter_cnt;
  logic        accept;
  logic        zero_div;

  assign accept = (state == IDLE) && start;

`ifdef GS_DIVZERO_EN
  assign zero_div = (D_in == 16'h0000);
`else
  assign zero_div = 1'b0;
`endif

  // State register, operand latches, iteration counter, done pulse and quotient capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      iter_cnt <= 3'd0;
      N        <= 16'h0000;
      D        <= 16'h0000;
      IA       <= 16'h0000;
      done     <= 1'b0;
      quotient <= 16'h0000;
    end else begin
      state <= next_state;
      done  <= (state == CAPT);
      if (accept) begin
        N        <= N_in;
        D        <= D_in;
        IA       <= IA_in;
        iter_cnt <= 3'd0;
      end else if (state == IT_D) begin
        iter_cnt <= iter_cnt + 3'd1;
      end
      if (state == CAPT) begin
`ifdef GS_DIVZERO_EN
        quotient <= (D == 16'h0000) ? 16'hFFFF : result;
`else
        quotient <= result;
`endif
      end
    end
  end

`ifdef GS_DIVZERO_EN
  // Divide-by-zero flag tracks the most recently captured quotient.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dz <= 1'b0;
    end else if (state == CAPT) begin
      dz <= (D == 16'h0000);
    end
  end
`else
  assign dz = 1'b0;
`endif

  // Next-state decode of the divide sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = zero_div ? CAPT : LOAD_D;
        end else begin
          next_state = IDLE;
        end
      end
      LOAD_D: next_state = LOAD_N;
      LOAD_N: next_state = IT_N;
      IT_N:   next_state = IT_D;
      IT_D: begin
        if (iter_cnt == LAST_ITER) begin
          next_state = FINAL;
        end else begin
          next_state = IT_N;
        end
      end
      FINAL:  next_state = CAPT;
      CAPT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore decode of the datapath controls and busy from the current state.
  always_comb begin
    kSelect  = 1'b0;
    ndSelect = 2'b00;
    nEnable  = 1'b0;
    dEnable  = 1'b0;
    busy     = (state != IDLE);
    case (state)
      LOAD_D: begin
        ndSelect = 2'b00;
        dEnable  = 1'b1;
      end
      LOAD_N: begin
        ndSelect = 2'b01;
        nEnable  = 1'b1;
      end
      IT_N: begin
        kSelect  = 1'b1;
        ndSelect = 2'b11;
        nEnable  = 1'b1;
      end
      IT_D: begin
        kSelect  = 1'b1;
        ndSelect = 2'b10;
        dEnable  = 1'b1;
      end
      FINAL: begin
        kSelect  = 1'b1;
        ndSelect = 2'b11;
        dEnable  = 1'b1;
      end
      default: begin
        kSelect  = 1'b0;
        ndSelect = 2'b00;
        nEnable  = 1'b0;
        dEnable  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Directed self-checking bench for goldschmidt_ctrl (ITERS=2).
module tb_goldschmidt_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] N_in, D_in, IA_in, result;
  logic [15:0] N, D, IA, quotient;
  logic        kSelect, nEnable, dEnable, busy, done, dz;
  logic [1:0]  ndSelect;

  int compared   = 0;
  int mismatched = 0;

  goldschmidt_ctrl #(.ITERS(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .N_in(N_in), .D_in(D_in), .IA_in(IA_in), .result(result),
    .N(N), .D(D), .IA(IA),
    .kSelect(kSelect), .ndSelect(ndSelect),
    .nEnable(nEnable), .dEnable(dEnable),
    .busy(busy), .done(done), .quotient(quotient), .dz(dz)
  );

  always #5 clk = ~clk;

  // Expected controls for cycles 1..8 of an ITERS=2 run (index 0 unused).
  logic [1:0] exp_nd [0:8] = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00};
  logic       exp_k  [0:8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       exp_de [0:8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic       exp_ne [0:8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic chk_ctrl(input string tag, input int c);
    chk({tag, " ndSelect"}, 32'(ndSelect), 32'(exp_nd[c]));
    chk({tag, " kSelect"},  32'(kSelect),  32'(exp_k[c]));
    chk({tag, " dEnable"},  32'(dEnable),  32'(exp_de[c]));
    chk({tag, " nEnable"},  32'(nEnable),  32'(exp_ne[c]));
    chk({tag, " busy"},     32'(busy),     32'd1);
    chk({tag, " done"},     32'(done),     32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b1;
    N_in = 16'h1111; D_in = 16'h2222; IA_in = 16'h3333; result = 16'h0000;

    // Reset held for two cycles with start asserted.
    tick(); tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst quotient", 32'(quotient), 32'd0);
    chk("rst enables", 32'({nEnable, dEnable, kSelect, ndSelect}), 32'd0);
    chk("rst operands", {16'h0, N | D | IA}, 32'd0);
    chk("rst dz", 32'(dz), 32'd0);

    // Run 1: N=4000 D=8000 IA=8000, stray starts in cycles 3 and 5.
    reset = 1'b1; start = 1'b0; tick();
    N_in = 16'h4000; D_in = 16'h8000; IA_in = 16'h8000; start = 1'b1;
    tick();
    start = 1'b0; N_in = 16'h0AAA; D_in = 16'h0BBB; IA_in = 16'h0CCC;
    for (int c = 1; c <= 8; c++) begin
      chk_ctrl($sformatf("run1 c%0d", c), c);
      start  = (c == 3 || c == 5);
      result = 16'h5000 + 16'(c);
      tick();
    end
    // Cycle 9: done, quotient from the CAPT cycle, operands unchanged.
    chk("run1 done", 32'(done), 32'd1);
    chk("run1 busy", 32'(busy), 32'd0);
    chk("run1 quotient", 32'(quotient), 32'h5008);
    chk("run1 N", 32'(N), 32'h4000);
    chk("run1 D", 32'(D), 32'h8000);
    chk("run1 IA", 32'(IA), 32'h8000);

    // Back-to-back: start in the done cycle.
    N_in = 16'h1234; D_in = 16'h9000; IA_in = 16'h7000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 10; c <= 17; c++) begin
      chk_ctrl($sformatf("run2 c%0d", c), c - 9);
      chk($sformatf("run2 held q c%0d", c), 32'(quotient), 32'h5008);
      result = 16'h6000 + 16'(c);
      tick();
    end
    chk("run2 done", 32'(done), 32'd1);
    chk("run2 quotient", 32'(quotient), 32'h6011);
    chk("run2 D", 32'(D), 32'h9000);
    tick();
    chk("run2 done width", 32'(done), 32'd0);

    // Reset asserted in cycle 5 of a run.
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    reset = 1'b0; tick(); reset = 1'b1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst quotient", 32'(quotient), 32'd0);
    chk("midrst enables", 32'({nEnable, dEnable, kSelect, ndSelect}), 32'd0);
    chk("midrst N", 32'(N), 32'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 12; c++) begin
        if (done) seen++;
        tick();
      end
      chk("midrst no done", 32'(seen), 32'd0);
    end

`ifdef GS_DIVZERO_EN
    // Zero divisor short-circuits to CAPT.
    N_in = 16'h4000; D_in = 16'h0000; IA_in = 16'h8000; start = 1'b1;
    tick(); start = 1'b0; result = 16'h1234;
    chk("dz enables", 32'({nEnable, dEnable, kSelect, ndSelect}), 32'd0);
    chk("dz busy", 32'(busy), 32'd1);
    tick();
    chk("dz done", 32'(done), 32'd1);
    chk("dz quotient", 32'(quotient), 32'hFFFF);
    chk("dz flag", 32'(dz), 32'd1);
    D_in = 16'h8000; start = 1'b1;
    tick(); start = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    chk("dz clear done", 32'(done), 32'd1);
    chk("dz clear flag", 32'(dz), 32'd0);
`else
    // Zero divisor runs the full sequence with dz held low.
    N_in = 16'h4000; D_in = 16'h0000; IA_in = 16'h8000; start = 1'b1;
    tick(); start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      result = 16'h7000 + 16'(c);
      if (c == 1) chk("d0 dEnable", 32'(dEnable), 32'd1);
      tick();
    end
    chk("d0 done", 32'(done), 32'd1);
    chk("d0 quotient", 32'(quotient), 32'h7008);
    chk("d0 dz", 32'(dz), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
